// File: rtl/cache_ctrl.sv
// Miss-handling controller for a 2-way write-back cache: issues lookups, writes back a dirty
// victim word by word, refills the line from memory and replays the CPU access.
module cache_ctrl #(
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_rd,
    input  logic                 req_wr,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          din,
    input  logic [2:0]           u_b_h_w,
    output logic                 stall,
    output logic [31:0]          dout,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [ADDR_BITS-10:0] cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);
    localparam int unsigned CntBits = $clog2(LINE_WORDS);
    localparam logic [CntBits-1:0] LastWord = CntBits'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWbRead,
        StWbWrite,
        StRefill,
        StReplay
    } state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] req_addr_q;
    logic [31:0]          req_din_q;
    logic [2:0]           req_ubhw_q;
    logic                 is_wr_q;
    logic [ADDR_BITS-10:0] victim_tag_q;
    logic [CntBits-1:0]   word_cnt_q;

    logic                 req;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [ADDR_BITS-1:0] fill_addr;

    assign req       = req_rd | req_wr;
    assign wb_addr   = {victim_tag_q, req_addr_q[8:4], word_cnt_q, 2'b00};
    assign fill_addr = {req_addr_q[ADDR_BITS-1:9], req_addr_q[8:4], word_cnt_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_addr_q   <= '0;
            req_din_q    <= '0;
            req_ubhw_q   <= '0;
            is_wr_q      <= 1'b0;
            victim_tag_q <= '0;
            word_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        req_addr_q <= addr;
                        req_din_q  <= din;
                        req_ubhw_q <= u_b_h_w;
                        // Simultaneous rd and wr is treated as a read.
                        is_wr_q    <= req_wr & ~req_rd;
                        state_q    <= StCompare;
                    end
                end
                StCompare: begin
                    if (cache_hit) begin
                        state_q <= StIdle;
                    end else begin
                        victim_tag_q <= cache_tag;
                        word_cnt_q   <= '0;
                        state_q      <= (cache_valid & cache_dirty) ? StWbRead : StRefill;
                    end
                end
                StWbRead: state_q <= StWbWrite;
                StWbWrite: begin
                    if (mem_ack) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        state_q    <= (word_cnt_q == LastWord) ? StRefill : StWbRead;
                    end
                end
                StRefill: begin
                    if (mem_ack) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (word_cnt_q == LastWord) begin
                            state_q <= StReplay;
                        end
                    end
                end
                StReplay: state_q <= StCompare;
                default:  state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall         = 1'b0;
        cache_addr    = req_addr_q;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_u_b_h_w = req_ubhw_q;
        cache_din     = req_din_q;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    stall         = 1'b1;
                    cache_addr    = addr;
                    cache_load    = req_rd;
                    cache_edit    = req_wr & ~req_rd;
                    cache_u_b_h_w = u_b_h_w;
                    cache_din     = din;
                end
            end
            StCompare: stall = ~cache_hit;
            StWbRead: begin
                stall      = 1'b1;
                cache_addr = wb_addr;
            end
            StWbWrite: begin
                // Keep the array pointed at the victim word so cache_dout holds through the wait.
                stall      = 1'b1;
                cache_addr = wb_addr;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = wb_addr;
                mem_wdata  = cache_dout;
            end
            StRefill: begin
                stall      = 1'b1;
                cache_addr = fill_addr;
                mem_cs     = 1'b1;
                mem_addr   = fill_addr;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_rdata;
                end
            end
            StReplay: begin
                stall      = 1'b1;
                cache_load = ~is_wr_q;
                cache_edit = is_wr_q;
            end
            default: stall = 1'b0;
        endcase
    end

    assign cache_invalid = 1'b0;
    assign dout          = cache_dout;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural 2-way cache array and a memory with
// programmable ack latency.
module tb_cache_ctrl;
    localparam logic [2:0] LB = 3'b000, LW = 3'b010, LBU = 3'b100, SB = 3'b000;

    logic        clk, rst, req_rd, req_wr;
    logic [31:0] addr, din, dout, cache_addr, cache_din, cache_dout;
    logic [2:0]  u_b_h_w, cache_u_b_h_w;
    logic        stall, cache_load, cache_store, cache_edit, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic        mem_cs, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .din(din),
        .u_b_h_w(u_b_h_w), .stall(stall), .dout(dout), .cache_addr(cache_addr),
        .cache_load(cache_load), .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack after lat wait cycles (lat=0 acks in the first cycle).
    logic [31:0] mem [0:1023];
    int lat, wait_cnt;
    logic arr_init;
    assign mem_ack   = mem_cs && (wait_cnt == lat);
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) wait_cnt <= (mem_cs && !mem_ack) ? wait_cnt + 1 : 0;

    // Cache array model.
    logic [31:0] data_a [2][32][4];
    logic [22:0] tag_a [2][32];
    logic        valid_a [2][32];
    logic        dirty_a [2][32];
    logic        lru_a [32];
    logic [4:0]  m_idx;
    logic [22:0] m_tag;
    logic [1:0]  m_w, m_bo;
    logic        m_hit0, m_hit1, m_way, m_vic;
    logic [31:0] m_word;

    always_comb begin
        m_idx  = cache_addr[8:4];
        m_tag  = cache_addr[31:9];
        m_w    = cache_addr[3:2];
        m_bo   = cache_addr[1:0];
        m_hit0 = valid_a[0][m_idx] && (tag_a[0][m_idx] == m_tag);
        m_hit1 = valid_a[1][m_idx] && (tag_a[1][m_idx] == m_tag);
        m_way  = m_hit1;
        m_vic  = lru_a[m_idx];
        m_word = data_a[m_way][m_idx][m_w];
    end

    function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] bo,
                                           input logic [2:0] c);
        logic [31:0] s;
        s = w >> {bo, 3'b000};
        case (c)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] bo, input logic [2:0] c);
        logic [31:0] m;
        case (c[1:0])
            2'b00:   m = 32'h0000_00ff;
            2'b01:   m = 32'h0000_ffff;
            default: m = 32'hffff_ffff;
        endcase
        m = m << {bo, 3'b000};
        return (w & ~m) | ((d << {bo, 3'b000}) & m);
    endfunction

    always @(posedge clk) begin
        if (arr_init) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 32; s++) begin
                    valid_a[w][s] <= 1'b0;
                    dirty_a[w][s] <= 1'b0;
                    tag_a[w][s]   <= '0;
                    lru_a[s]      <= 1'b0;
                end
            // Word at byte address a holds ((a>>8)-1)<<16 | (word+1)*0x11.
            for (int i = 0; i < 1024; i++)
                mem[i] <= (((i * 4) >> 8) - 1) << 16 | ((i % 4) + 1) * 32'h11;
            cache_hit <= 1'b0; cache_valid <= 1'b0; cache_dirty <= 1'b0;
            cache_tag <= '0;   cache_dout  <= '0;
        end else begin
            if (cache_load || cache_edit) begin
                if (m_hit0 || m_hit1) begin
                    cache_hit   <= 1'b1;
                    cache_valid <= 1'b1;
                    cache_dirty <= dirty_a[m_way][m_idx];
                    cache_tag   <= m_tag;
                    lru_a[m_idx] <= ~m_way;
                    if (cache_load) begin
                        cache_dout <= ld_fmt(m_word, m_bo, cache_u_b_h_w);
                    end else begin
                        data_a[m_way][m_idx][m_w] <= st_merge(m_word, cache_din, m_bo,
                                                              cache_u_b_h_w);
                        dirty_a[m_way][m_idx] <= 1'b1;
                    end
                end else begin
                    cache_hit   <= 1'b0;
                    cache_valid <= valid_a[m_vic][m_idx];
                    cache_dirty <= dirty_a[m_vic][m_idx];
                    cache_tag   <= tag_a[m_vic][m_idx];
                end
            end else begin
                cache_hit  <= 1'b0;
                cache_dout <= m_word;
                if (cache_store) begin
                    if (m_hit0 || m_hit1) begin
                        data_a[m_way][m_idx][m_w] <= cache_din;
                    end else begin
                        tag_a[m_vic][m_idx]       <= m_tag;
                        valid_a[m_vic][m_idx]     <= 1'b1;
                        dirty_a[m_vic][m_idx]     <= 1'b0;
                        data_a[m_vic][m_idx][m_w] <= cache_din;
                    end
                end
            end
            if (mem_cs && mem_we && mem_ack) mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    // Bus monitor: acked ops, per-op cycle length, output stability while waiting.
    logic [31:0] op_addr[$], op_data[$];
    logic        op_we[$];
    int          op_len[$];
    int          run, unstable, n_store, n_cs, bad_store;
    logic        in_op, p_we;
    logic [31:0] p_addr, p_wdata;
    initial begin
        run = 0; unstable = 0; n_store = 0; n_cs = 0; bad_store = 0; in_op = 1'b0;
    end
    always @(posedge clk) begin
        if (mem_cs) begin
            n_cs <= n_cs + 1;
            if (in_op && (mem_we != p_we || mem_addr != p_addr || mem_wdata != p_wdata))
                unstable <= unstable + 1;
            if (mem_ack) begin
                op_addr.push_back(mem_addr);
                op_data.push_back(mem_we ? mem_wdata : mem_rdata);
                op_we.push_back(mem_we);
                op_len.push_back(run + 1);
                run   <= 0;
                in_op <= 1'b0;
            end else begin
                run     <= run + 1;
                in_op   <= 1'b1;
                p_we    <= mem_we;
                p_addr  <= mem_addr;
                p_wdata <= mem_wdata;
            end
        end else begin
            run   <= 0;
            in_op <= 1'b0;
        end
        if (cache_store) n_store <= n_store + 1;
        if (cache_store && !(mem_cs && mem_ack)) bad_store <= bad_store + 1;
    end

    int n_chk, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Call at posedge+1; returns cycles until stall low (inclusive) and dout in that cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c,
                          output int cyc, output logic [31:0] data);
        req_rd = rd; req_wr = wr; addr = a; din = d; u_b_h_w = c;
        cyc = 0; data = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (!stall) begin
                data = dout;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_rd = 1'b0; req_wr = 1'b0; addr = '0; din = '0; u_b_h_w = '0;
    endtask

    function automatic logic [31:0] ctl_vec();
        return {25'h0, stall, cache_load, cache_store, cache_edit, cache_invalid, mem_cs, mem_we};
    endfunction

    initial begin
        int cyc, q0, l0, s0, c0, found;
        logic [31:0] data;
        logic [31:0] exp_wb [4];
        exp_wb[0] = 32'h11; exp_wb[1] = 32'h22; exp_wb[2] = 32'h0000ab33; exp_wb[3] = 32'h44;
        n_chk = 0; n_bad = 0;
        rst = 1'b1; arr_init = 1'b1; lat = 1;
        req_rd = 1'b0; req_wr = 1'b0; addr = '0; din = '0; u_b_h_w = '0;
        repeat (2) @(posedge clk);
        #1 arr_init = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", ctl_vec(), 32'h0);
        check("rst_cache_addr", cache_addr, 32'h0);
        check("rst_cache_din", cache_din, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;

        // Cold read miss, A=1.
        q0 = op_addr.size(); s0 = n_store;
        do_req(1'b1, 1'b0, 32'h104, 32'h0, LW, cyc, data);
        check("cold_cycles", cyc, 12);
        check("cold_dout", data, 32'h22);
        check("cold_stores", n_store - s0, 4);
        check("cold_nops", op_addr.size() - q0, 4);
        for (int i = 0; i < 4; i++) begin
            check("cold_rd_addr", op_addr[q0 + i], 32'h100 + 4 * i);
            check("cold_rd_we", 32'(op_we[q0 + i]), 32'h0);
        end

        // Hits: no memory traffic, 2 cycles each.
        c0 = n_cs;
        do_req(1'b1, 1'b0, 32'h108, 32'h0, LW, cyc, data);
        check("hit_cycles", cyc, 2);
        check("hit_dout", data, 32'h33);
        do_req(1'b0, 1'b1, 32'h109, 32'hab, SB, cyc, data);
        check("sb_cycles", cyc, 2);
        do_req(1'b1, 1'b0, 32'h109, 32'h0, LB, cyc, data);
        check("lb_cycles", cyc, 2);
        check("lb_dout", data, 32'hffffffab);
        do_req(1'b1, 1'b0, 32'h109, 32'h0, LBU, cyc, data);
        check("lbu_cycles", cyc, 2);
        check("lbu_dout", data, 32'h000000ab);
        check("hit_mem_cs", n_cs - c0, 0);

        // Dirty eviction, A=0.
        lat = 0;
        do_req(1'b1, 1'b0, 32'h304, 32'h0, LW, cyc, data);
        check("clean0_cycles", cyc, 8);
        check("clean0_dout", data, 32'h00020022);
        q0 = op_addr.size();
        do_req(1'b1, 1'b0, 32'h504, 32'h0, LW, cyc, data);
        check("dirty_cycles", cyc, 16);
        check("dirty_dout", data, 32'h00040022);
        check("dirty_nops", op_addr.size() - q0, 8);
        if (op_addr.size() - q0 == 8) begin
            for (int i = 0; i < 4; i++) begin
                check("wb_addr", op_addr[q0 + i], 32'h100 + 4 * i);
                check("wb_we", 32'(op_we[q0 + i]), 32'h1);
                check("wb_data", op_data[q0 + i], exp_wb[i]);
                check("fill_addr", op_addr[q0 + 4 + i], 32'h500 + 4 * i);
                check("fill_we", 32'(op_we[q0 + 4 + i]), 32'h0);
            end
        end

        // Backpressure, A=5.
        lat = 5;
        l0 = op_len.size(); s0 = n_store;
        do_req(1'b1, 1'b0, 32'h704, 32'h0, LW, cyc, data);
        check("bp_cycles", cyc, 28);
        check("bp_dout", data, 32'h00060022);
        check("bp_nops", op_len.size() - l0, 4);
        if (op_len.size() - l0 == 4)
            for (int i = 0; i < 4; i++) check("bp_len", op_len[l0 + i], 6);
        check("bp_stores", n_store - s0, 4);
        check("bp_unstable", unstable, 0);

        // Reset in the middle of refill word 2, A=1.
        lat = 1;
        req_rd = 1'b1; addr = 32'h904; u_b_h_w = LW;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_cs && mem_addr == 32'h908) begin
                found = 1;
                break;
            end
        end
        check("rst_reach_word2", found, 1);
        @(posedge clk);
        #1 rst = 1'b1; req_rd = 1'b0; addr = '0; u_b_h_w = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ctl", ctl_vec(), 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 32'h904, 32'h0, LW, cyc, data);
        check("post_rst_cycles", cyc, 2);
        check("post_rst_dout", data, 32'h00080022);
        check("store_outside_ack", bad_store, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss-handling controller between the CPU data port, the 2-way set-associative write-back cache array and main memory. It turns CPU load/store requests into cache lookup strobes. On a miss it writes back a dirty LRU victim line word by word, then refills the line from memory and replays the access. It is the initiator side of the array's load/store/edit/invalid interface and the master on the memory bus.

## Interface
- ADDR_BITS, 32, byte address width
- LINE_WORDS, 4, words per line (2-bit word counter)
- Address split: tag [31:9], index [8:4], word [3:2], byte [1:0]

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_rd  in  1  CPU load request, held until stall low
- req_wr  in  1  CPU store request, held until stall low
- addr  in  32  CPU byte address
- din  in  32  CPU store data (right-aligned)
- u_b_h_w  in  3  width/sign code, passed to array
- stall  out  1  CPU wait; combinational
- dout  out  32  load data = cache_dout; valid in the cycle stall falls
- cache_addr  out  32  array address
- cache_load, cache_store, cache_edit, cache_invalid  out  1 each  array strobes
- cache_u_b_h_w  out  3
- cache_din  out  32
- cache_hit, cache_valid, cache_dirty  in  1 each  array status, registered one cycle after strobe; on miss they describe the LRU victim way
- cache_tag  in  23  tag of hit way or of the victim on a miss
- cache_dout  in  32  array read data, registered
- mem_cs, mem_we  out  1 each  memory select / write enable
- mem_addr  out  32  word-aligned
- mem_wdata  out  32
- mem_rdata  in  32
- mem_ack  in  1  op complete this cycle; may be same-cycle (latency A ≥ 0)

## Operation
- Latch regs: req_addr, req_din, req_ubhw, is_wr, victim_tag, word_cnt[1:0].
- Requests with both req_rd and req_wr high are treated as reads.
- States:
  - IDLE: on a request, latch the request and drive cache_addr=addr. Drive cache_load=req_rd, or cache_edit=req_wr&!req_rd. Go to COMPARE.
  - COMPARE: if cache_hit, finish: stall=0 this cycle, go to IDLE. Otherwise latch victim_tag=cache_tag and clear word_cnt. Go to WB_READ if cache_valid&cache_dirty, else REFILL.
  - WB_READ: drive cache_addr={victim_tag,index,word_cnt,00} with all strobes 0. The array returns the victim word next cycle. Go to WB_WRITE.
  - WB_WRITE: mem_cs=1, mem_we=1, mem_addr={victim_tag,index,word_cnt,00}, mem_wdata=cache_dout. Hold until mem_ack. On ack: word_cnt+1; if word_cnt==3, clear it and go to REFILL, else go to WB_READ.
  - REFILL: mem_cs=1, mem_we=0, mem_addr={req_tag,index,word_cnt,00}, held until mem_ack. In the ack cycle, drive cache_store=1, cache_addr=mem_addr and cache_din=mem_rdata. Then word_cnt+1; after word 3, go to REPLAY.
  - REPLAY: re-issue the latched request (cache_load or cache_edit, with req_addr, req_din and req_ubhw). Go to COMPARE, which now hits.
- Store never updates recency, so all four refill words land in the same victim way.
- stall = (IDLE & request) | (state≠IDLE & !(COMPARE & cache_hit)).
- cache_invalid is tied to 0.
- Memory outputs (mem_cs, mem_we, mem_addr, mem_wdata) are stable from mem_cs rise through the ack cycle inclusive.

## Timing
- Reset: state IDLE, word_cnt 0, all latches 0. stall, all cache strobes, mem_cs and mem_we are 0, and all address/data outputs are 0 on the edge after rst.
- Reset mid-operation: abandons the transaction on the next edge; mem_cs drops immediately. The array is not scrubbed; a partially refilled line remains as stored, and array reset belongs to the array owner.
- Hit: 2 cycles (IDLE issue, COMPARE respond).
- Clean miss: 4A+8 cycles.
- Dirty miss: 8A+16 cycles.
- A new request may be accepted in the cycle after stall falls (IDLE).
- mem_ack outside WB_WRITE or REFILL is ignored.

## Test plan
- Cold read miss, A=1: after reset, LW 0x104; memory 0x100..0x10C = 0x11, 0x22, 0x33, 0x44. Required: reads in address order, 4 cache_store pulses, 11 stall-high cycles, then dout=0x22 with stall low.
- Read hit: LW 0x108 -> 2 cycles, dout=0x33, mem_cs never asserted.
- Write hit then loads: SB 0x109 din=0xAB, then LB 0x109 -> 0xFFFFFFAB and LBU -> 0x000000AB.
  - The two loads take 2 cycles each and cause no memory traffic.
- Dirty eviction, A=0: load 0x304 (fills other way); this makes the 0x100 line LRU. Then LW 0x504.
  - Required: writes to 0x100, 0x104, 0x108, 0x10C with data 0x11, 0x22, 0x0000AB33, 0x44.
  - Then reads 0x500..0x50C; total 16 cycles.
- Backpressure: A=5 -> mem_cs, mem_we, mem_addr and mem_wdata are constant for 6 cycles per word; exactly one cache_store per ack.
- Reset mid-refill: rst during word 2 -> next cycle IDLE, mem_cs=0, stall=0, strobes 0.
  - A read issued the following cycle completes normally.
